// File: rtl/fetch_decode_unit.sv
// Fetch and decode-register stage: fetches 16-bit words over a req/ack handshake
// and presents the decoded fields of the latched instruction under valid/ready.
module fetch_decode_unit #(
  parameter int                     PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
  parameter int                     PC_INC   = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [3:0]          opcode,
  output logic [2:0]          rs,
  output logic [2:0]          rt,
  output logic [2:0]          rd,
  output logic [2:0]          funct,
  output logic [5:0]          imm6
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pcNext;
  logic [PC_WIDTH-1:0] r_pcOut;
  logic [PC_WIDTH-1:0] w_pcOutNext;
  logic [PC_WIDTH-1:0] r_drainAddr;
  logic [PC_WIDTH-1:0] w_drainAddrNext;
  logic [15:0]         r_ir;
  logic [15:0]         w_irNext;
  logic [PC_WIDTH-1:0] w_redirPc;

  assign w_redirPc = redirect_pc & ~PC_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_pcOut     <= '0;
      r_drainAddr <= '0;
      r_ir        <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_pc        <= w_pcNext;
      r_pcOut     <= w_pcOutNext;
      r_drainAddr <= w_drainAddrNext;
      r_ir        <= w_irNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_pcNext        = r_pc;
    w_pcOutNext     = r_pcOut;
    w_drainAddrNext = r_drainAddr;
    w_irNext        = r_ir;
    case (r_state)
      IDLE: begin
        if (redirect) w_pcNext = w_redirPc;
        w_stateNext = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          w_pcNext = w_redirPc;
          // An unacknowledged request cannot be withdrawn; remember its address
          // so the bus stays stable while we wait to throw its data away.
          if (!imem_ack) begin
            w_drainAddrNext = r_pc;
            w_stateNext     = DRAIN;
          end
        end else if (imem_ack) begin
          w_irNext    = imem_rdata;
          w_pcOutNext = r_pc;
          w_pcNext    = r_pc + PC_WIDTH'(PC_INC);
          w_stateNext = VALID;
        end
      end
      VALID: begin
        if (redirect) begin
          w_pcNext    = w_redirPc;
          w_stateNext = FETCH;
        end else if (dec_ready) begin
          w_stateNext = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) w_pcNext = w_redirPc;
        if (imem_ack) w_stateNext = FETCH;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign imem_req  = (r_state == FETCH) || (r_state == DRAIN);
  assign imem_addr = (r_state == DRAIN) ? r_drainAddr : r_pc;
  assign dec_valid = (r_state == VALID);
  assign pc_out    = r_pcOut;
  assign opcode    = r_ir[15:12];
  assign rs        = r_ir[11:9];
  assign rt        = r_ir[8:6];
  assign rd        = r_ir[5:3];
  assign funct     = r_ir[2:0];
  assign imm6      = r_ir[5:0];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: a transaction-level model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_fetch_decode_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] pc_out;
   logic [3:0]  opcode;
   logic [2:0]  rs, rt, rd, funct;
   logic [5:0]  imm6;

   int assertCount = 0;
   int failCount = 0;
   bit checkEn = 1'b0;

   // Model state: what the fetch stage is doing, in transaction terms.
   bit          mIdle = 1'b0;
   bit          mOutstanding = 1'b0;
   bit          mDiscard = 1'b0;
   bit          mHolding = 1'b0;
   logic [31:0] mPc = '0;
   logic [31:0] mReqAddr = '0;
   logic [31:0] mPcOut = '0;
   logic [15:0] mIr = '0;

   fetch_decode_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .PC_INC(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt),
      .rd(rd), .funct(funct), .imm6(imm6)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge, so the model sees the same values as the DUT.
   always @(posedge clk) begin : model
      logic [31:0] target;
      target = redirect_pc & 32'hFFFF_FFFE;
      if (reset) begin
         mIdle = 1'b1; mOutstanding = 1'b0; mDiscard = 1'b0; mHolding = 1'b0;
         mPc = 32'h0; mReqAddr = 32'h0; mPcOut = 32'h0; mIr = 16'h0;
      end else if (mIdle) begin
         if (redirect) mPc = target;
         mIdle = 1'b0; mOutstanding = 1'b1; mReqAddr = mPc;
      end else if (mHolding) begin
         if (redirect) mPc = target;
         if (redirect || dec_ready) begin
            mHolding = 1'b0; mOutstanding = 1'b1; mReqAddr = mPc;
         end
      end else if (mOutstanding) begin
         if (imem_ack) begin
            if (mDiscard || redirect) begin
               if (redirect) mPc = target;
               mDiscard = 1'b0; mReqAddr = mPc;
            end else begin
               mIr = imem_rdata; mPcOut = mReqAddr; mPc = mReqAddr + 32'd2;
               mOutstanding = 1'b0; mHolding = 1'b1;
            end
         end else if (redirect) begin
            mPc = target; mDiscard = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("req", 32'(imem_req), 32'(mOutstanding));
         if (mOutstanding) checkOutput("addr", imem_addr, mReqAddr);
         checkOutput("valid", 32'(dec_valid), 32'(mHolding));
         checkOutput("pc_out", pc_out, mPcOut);
         checkOutput("opcode", 32'(opcode), 32'(mIr[15:12]));
         checkOutput("rs", 32'(rs), 32'(mIr[11:9]));
         checkOutput("rt", 32'(rt), 32'(mIr[8:6]));
         checkOutput("rd", 32'(rd), 32'(mIr[5:3]));
         checkOutput("funct", 32'(funct), 32'(mIr[2:0]));
         checkOutput("imm6", 32'(imm6), 32'(mIr[5:0]));
      end
   end

   task automatic applyStimulus(input bit rst, input bit ack, input logic [15:0] rdata,
                                input bit ready, input bit redir, input logic [31:0] rpc);
      reset = rst; imem_ack = ack; imem_rdata = rdata;
      dec_ready = ready; redirect = redir; redirect_pc = rpc;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 32'h44);
      checkEn = 1'b1;
      checkOutput("rst_req", 32'(imem_req), 32'd0);
      checkOutput("rst_valid", 32'(dec_valid), 32'd0);
      checkOutput("rst_pc_out", pc_out, 32'd0);

      // IDLE -> FETCH at address 0
      quiet();
      checkOutput("first_req", 32'(imem_req), 32'd1);
      checkOutput("first_addr", imem_addr, 32'h0);

      // 1-cycle ack of 16'h1A3F
      applyStimulus(1'b0, 1'b1, 16'h1A3F, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_valid", 32'(dec_valid), 32'd1);
      checkOutput("t1_opcode", 32'(opcode), 32'd1);
      checkOutput("t1_rs", 32'(rs), 32'd5);
      checkOutput("t1_rt", 32'(rt), 32'd0);
      checkOutput("t1_imm6", 32'(imm6), 32'h3F);
      checkOutput("t1_pc_out", pc_out, 32'h0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_next_addr", imem_addr, 32'h2);
      checkOutput("t1_next_req", 32'(imem_req), 32'd1);

      // Stall with 16'hF2C5 held for 5 cycles
      applyStimulus(1'b0, 1'b1, 16'hF2C5, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         quiet();
         checkOutput("stall_valid", 32'(dec_valid), 32'd1);
         checkOutput("stall_req", 32'(imem_req), 32'd0);
         checkOutput("stall_opcode", 32'(opcode), 32'hF);
         checkOutput("stall_rt", 32'(rt), 32'd3);
         checkOutput("stall_imm6", 32'(imm6), 32'h05);
         checkOutput("stall_pc_out", pc_out, 32'h2);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("release_req", 32'(imem_req), 32'd1);
      checkOutput("release_addr", imem_addr, 32'h4);

      // Redirect during FETCH before ack
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 32'h101);
      quiet();
      quiet();
      checkOutput("drain_addr", imem_addr, 32'h4);
      checkOutput("drain_req", 32'(imem_req), 32'd1);
      applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 32'h0);
      checkOutput("drain_done_valid", 32'(dec_valid), 32'd0);
      checkOutput("drain_done_addr", imem_addr, 32'h100);

      // Redirect in the same cycle as ack
      applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 32'h200);
      checkOutput("redir_ack_req", 32'(imem_req), 32'd1);
      checkOutput("redir_ack_addr", imem_addr, 32'h200);
      applyStimulus(1'b0, 1'b1, 16'h3456, 1'b0, 1'b0, 32'h0);
      checkOutput("redir_ack_pc_out", pc_out, 32'h200);

      // Redirect with dec_ready in VALID
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 32'h300);
      checkOutput("redir_valid_addr", imem_addr, 32'h300);
      checkOutput("redir_valid_valid", 32'(dec_valid), 32'd0);

      // Back-to-back redirects while draining: newest wins
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 32'h400);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 32'h500);
      checkOutput("newest_drain_addr", imem_addr, 32'h300);
      applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 32'h0);
      checkOutput("newest_addr", imem_addr, 32'h500);

      // PC wrap
      applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      checkOutput("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFE);
      applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap_pc_out", pc_out, 32'hFFFF_FFFE);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_addr", imem_addr, 32'h0);

      // Reset while draining with ack pending
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 32'h40);
      applyStimulus(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_drain_req", 32'(imem_req), 32'd0);
      checkOutput("rst_drain_opcode", 32'(opcode), 32'd0);
      checkOutput("rst_drain_pc_out", pc_out, 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 32'h81);
      checkOutput("idle_redir_addr", imem_addr, 32'h80);

      // Random traffic, checked by the model every cycle
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                       16'($urandom), ($urandom_range(0, 1) == 0),
                       ($urandom_range(0, 9) == 0), $urandom);
      end
      quiet();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
